// File: rtl/multimode_ff_bank_pkg.sv
// ----------------------------------------------------------------------------
// multimode_ff_bank_pkg
//   Shared definitions for the multimode flip-flop bank: the 3-bit mode
//   encoding and the per-bit next-state rule used by every cell.
// ----------------------------------------------------------------------------
package multimode_ff_bank_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_D      = 3'b000,
        MODE_T      = 3'b001,
        MODE_JK     = 3'b010,
        MODE_SR     = 3'b011,
        MODE_CNT_UP = 3'b100,
        MODE_CNT_DN = 3'b101,
        MODE_HOLD0  = 3'b110,
        MODE_HOLD1  = 3'b111
    } mode_e;

    // True for the two counter modes, where a/b are ignored.
    function automatic logic is_count_mode(input mode_e m);
        return (m == MODE_CNT_UP) || (m == MODE_CNT_DN);
    endfunction

    // Next value of one bit for an enabled, non-cleared edge.
    // tog is the cascade toggle request, only meaningful in count modes.
    function automatic logic ff_next(input mode_e m, input logic q,
                                     input logic a, input logic b,
                                     input logic tog);
        logic r;
        r = q;
        case (m)
            MODE_D:  r = a;
            MODE_T:  r = q ^ a;
            MODE_JK: begin
                case ({a, b})
                    2'b00:   r = q;
                    2'b01:   r = 1'b0;
                    2'b10:   r = 1'b1;
                    2'b11:   r = ~q;
                    default: r = q;
                endcase
            end
            MODE_SR: begin
                // S=R=1 is illegal: the bit holds and the cell flags it.
                case ({a, b})
                    2'b01:   r = 1'b0;
                    2'b10:   r = 1'b1;
                    default: r = q;
                endcase
            end
            MODE_CNT_UP,
            MODE_CNT_DN: r = q ^ tog;
            default:     r = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/multimode_ff_bank_ff_cell.sv
// ----------------------------------------------------------------------------
// ff_cell
//   One-bit run-time selectable flip-flop (D / T / JK / SR / count cell).
//   Ports:
//     i_clk, i_rst   clock, asynchronous active-high reset
//     i_en, i_clr    clock enable, synchronous clear (clear wins)
//     i_mode         3-bit mode (see multimode_ff_bank_pkg::mode_e)
//     i_a, i_b       D/T/J/S and K/R inputs
//     i_tog          cascade toggle request used in count modes
//     o_q            registered bit state
//     o_sr_ill       SR mode with S=R=1 on this bit (combinational)
// ----------------------------------------------------------------------------
module ff_cell
    import multimode_ff_bank_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_a,
    input  logic              i_b,
    input  logic              i_tog,
    output logic              o_q,
    output logic              o_sr_ill
);

    logic  r_q;
    logic  w_next;
    mode_e w_mode;

    // Decode mode and compute the enabled next state and illegal-SR flag.
    always_comb begin
        w_mode   = mode_e'(i_mode);
        w_next   = ff_next(w_mode, r_q, i_a, i_b, i_tog);
        o_sr_ill = (w_mode == MODE_SR) & i_a & i_b;
    end

    // State bit: reset > clear > enable > hold.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= RESET_BIT;
        end else if (i_clr) begin
            r_q <= RESET_BIT;
        end else if (i_en) begin
            r_q <= w_next;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/multimode_ff_bank.sv
// ----------------------------------------------------------------------------
// multimode_ff_bank
//   WIDTH-channel register where every bit is a selectable D/T/JK/SR
//   flip-flop; also a synchronous up/down counter built from cascaded T cells.
//   Ports:
//     i_clk, i_rst   clock, asynchronous active-high reset
//     i_en           clock enable (0 = hold q)
//     i_clr          synchronous clear to RESET_VAL (wins over i_en)
//     i_mode         000 D, 001 T, 010 JK, 011 SR, 100 CNT_UP, 101 CNT_DN,
//                    11x HOLD
//     i_a, i_b       per-bit D/T/J/S and K/R inputs
//     o_q            registered state
//     o_qn           ~o_q
//     o_tc           registered terminal-count pulse (count modes only)
//     o_sr_err       sticky illegal S=R=1 flag
// ----------------------------------------------------------------------------
module multimode_ff_bank
    import multimode_ff_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    output logic [WIDTH-1:0]  o_q,
    output logic [WIDTH-1:0]  o_qn,
    output logic              o_tc,
    output logic              o_sr_err
);

    mode_e            w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_sr_ill;
    logic [WIDTH-1:0] w_tog;
    logic [WIDTH:0]   w_up_chain;   // [i] = all bits below i are 1
    logic [WIDTH:0]   w_dn_chain;   // [i] = all bits below i are 0
    logic             w_tc_next;
    logic             r_tc;
    logic             r_sr_err;

    // Toggle cascade: bit i toggles when all lower bits are 1 (up) or 0 (down).
    // Bit 0 always toggles, so WIDTH=1 simply flips in either count mode.
    always_comb begin
        w_mode        = mode_e'(i_mode);
        w_up_chain    = {(WIDTH+1){1'b0}};
        w_dn_chain    = {(WIDTH+1){1'b0}};
        w_up_chain[0] = 1'b1;
        w_dn_chain[0] = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_chain[i+1] = w_up_chain[i] & w_q[i];
            w_dn_chain[i+1] = w_dn_chain[i] & ~w_q[i];
        end
        if (w_mode == MODE_CNT_DN) begin
            w_tog = w_dn_chain[WIDTH-1:0];
        end else begin
            w_tog = w_up_chain[WIDTH-1:0];
        end
    end

    // Terminal count fires on the edge where the counter wraps; the full
    // chain output is exactly the "all ones" / "all zeros" condition.
    always_comb begin
        w_tc_next = 1'b0;
        if (i_clr || !i_en) begin
            w_tc_next = 1'b0;
        end else if (w_mode == MODE_CNT_UP) begin
            w_tc_next = w_up_chain[WIDTH];
        end else if (w_mode == MODE_CNT_DN) begin
            w_tc_next = w_dn_chain[WIDTH];
        end else begin
            w_tc_next = 1'b0;
        end
    end

    genvar g;
    generate
        for (g = 0; g < WIDTH; g++) begin : g_cell
            ff_cell #(
                .RESET_BIT (RESET_VAL[g])
            ) u_cell (
                .i_clk    (i_clk),
                .i_rst    (i_rst),
                .i_en     (i_en),
                .i_clr    (i_clr),
                .i_mode   (i_mode),
                .i_a      (i_a[g]),
                .i_b      (i_b[g]),
                .i_tog    (w_tog[g]),
                .o_q      (w_q[g]),
                .o_sr_ill (w_sr_ill[g])
            );
        end
    endgenerate

    // Terminal-count pulse register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_tc <= 1'b0;
        end else begin
            r_tc <= w_tc_next;
        end
    end

    // Sticky illegal-SR flag; only reset or clear removes it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr_err <= 1'b0;
        end else if (i_clr) begin
            r_sr_err <= 1'b0;
        end else if (i_en && (|w_sr_ill)) begin
            r_sr_err <= 1'b1;
        end else begin
            r_sr_err <= r_sr_err;
        end
    end

    assign o_q      = w_q;
    assign o_qn     = ~w_q;
    assign o_tc     = r_tc;
    assign o_sr_err = r_sr_err;

endmodule
